// File: rtl/int_src_pkg.sv
// rtl/int_src_pkg.sv - register map and reset values for the interrupt source conditioner
package int_src_pkg;

  localparam logic [2:0] ADR_TRIGM = 3'd0;
  localparam logic [2:0] ADR_POL   = 3'd1;
  localparam logic [2:0] ADR_PEND  = 3'd2;
  localparam logic [2:0] ADR_SWSET = 3'd3;
  localparam logic [2:0] ADR_RAW   = 3'd4;
  localparam logic [2:0] ADR_DBEN  = 3'd5;
  localparam logic [2:0] ADR_DBCNT = 3'd6;

  localparam logic [7:0] TRIGM_RST = 8'h00;
  localparam logic [7:0] POL_RST   = 8'hFF;
  localparam logic [7:0] PEND_RST  = 8'h00;
  localparam logic [7:0] DBEN_RST  = 8'h00;
  localparam logic [7:0] DBCNT_RST = 8'h00;

  // Registers whose write must realign edge history so no spurious event appears.
  function automatic logic is_trig_cfg(input logic [2:0] adr);
    return (adr == ADR_TRIGM) || (adr == ADR_POL);
  endfunction

  function automatic logic is_filt_cfg(input logic [2:0] adr);
    return (adr == ADR_DBEN) || (adr == ADR_DBCNT);
  endfunction

endpackage

// File: rtl/int_line_filter.sv
// rtl/int_line_filter.sv - one interrupt line: synchroniser, glitch filter and edge detector
module int_line_filter
  import int_src_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             irq_i,
  input  logic             dben_i,
  input  logic [CNT_W-1:0] dbcnt_i,
  input  logic             cnt_clr_i,
  output logic             s_o,
  output logic             f_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   p_q;
  logic                   s;
  logic                   f;

  assign s = sync_q[SYNC_STAGES-1];
  assign f = dben_i ? filt_q : s;

  // With the filter off filt_q shadows s so that enabling it later starts from a settled value.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (!dben_i) begin
      filt_d = s;
      cnt_d  = '0;
    end else if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (s != filt_q) begin
      if (cnt_q >= dbcnt_i) begin
        filt_d = s;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
      p_q    <= 1'b0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      p_q    <= f;
    end
  end

  assign s_o    = s;
  assign f_o    = f;
  assign rise_o = f & ~p_q;
  assign fall_o = ~f & p_q;

endmodule

// File: rtl/int_src_cond.sv
// rtl/int_src_cond.sv - per-line interrupt conditioner feeding the interrupt controller INT_ARR
// Holds the register file, pending latches, registered output and Wishbone read mux.
module int_src_cond
  import int_src_pkg::*;
#(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] IRQ_RAW,
  output logic [N-1:0] INT_ARR,
  input  logic [2:0]   WB_ADRi,
  input  logic [7:0]   WB_DATi,
  output logic [7:0]   WB_DATo,
  input  logic         WB_WEi,
  input  logic         WB_CYCi,
  input  logic         WB_STBi,
  output logic         WB_ACKo
);

  logic [N-1:0]     trigm_q, trigm_d;
  logic [N-1:0]     pol_q, pol_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     dben_q, dben_d;
  logic [CNT_W-1:0] dbcnt_q, dbcnt_d;
  logic [N-1:0]     int_q, int_d;

  logic [N-1:0] s, f, rise, fall, ev;
  logic [N-1:0] wdat, w1c, swset, trig_clr;
  logic         wr, cnt_clr;

  assign wr      = WB_CYCi & WB_STBi & WB_WEi;
  assign wdat    = WB_DATi[N-1:0];
  assign cnt_clr = wr & is_filt_cfg(WB_ADRi);

  for (genvar i = 0; i < N; i++) begin : g_line
    int_line_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_filt (
      .clk_i    (clk),
      .rst_ni   (rst),
      .irq_i    (IRQ_RAW[i]),
      .dben_i   (dben_q[i]),
      .dbcnt_i  (dbcnt_q),
      .cnt_clr_i(cnt_clr),
      .s_o      (s[i]),
      .f_o      (f[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  // Edge history follows f every cycle, which also covers the realignment on TRIGM/POL writes.
  assign ev       = (pol_q & rise) | (~pol_q & fall);
  assign w1c      = (wr && WB_ADRi == ADR_PEND)  ? wdat : '0;
  assign swset    = (wr && WB_ADRi == ADR_SWSET) ? wdat : '0;
  assign trig_clr = (wr && WB_ADRi == ADR_TRIGM) ? (trigm_q & ~wdat) : '0;

  always_comb begin
    trigm_d = trigm_q;
    pol_d   = pol_q;
    dben_d  = dben_q;
    dbcnt_d = dbcnt_q;
    if (wr) begin
      case (WB_ADRi)
        ADR_TRIGM: trigm_d = wdat;
        ADR_POL:   pol_d   = wdat;
        ADR_DBEN:  dben_d  = wdat;
        ADR_DBCNT: dbcnt_d = WB_DATi[CNT_W-1:0];
        default:   ;
      endcase
    end
  end

  // Set beats W1C so an event coinciding with a clear is kept; leaving edge mode drops the bit.
  always_comb begin
    pend_d = ((pend_q & ~w1c) | (trigm_q & (ev | swset))) & ~trig_clr;
    int_d  = (trigm_q & pend_d) | (~trigm_q & ~(f ^ pol_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trigm_q <= TRIGM_RST[N-1:0];
      pol_q   <= POL_RST[N-1:0];
      pend_q  <= PEND_RST[N-1:0];
      dben_q  <= DBEN_RST[N-1:0];
      dbcnt_q <= DBCNT_RST[CNT_W-1:0];
      int_q   <= '0;
    end else begin
      trigm_q <= trigm_d;
      pol_q   <= pol_d;
      pend_q  <= pend_d;
      dben_q  <= dben_d;
      dbcnt_q <= dbcnt_d;
      int_q   <= int_d;
    end
  end

  always_comb begin
    WB_DATo = 8'h00;
    case (WB_ADRi)
      ADR_TRIGM: WB_DATo = 8'(trigm_q);
      ADR_POL:   WB_DATo = 8'(pol_q);
      ADR_PEND:  WB_DATo = 8'(pend_q);
      ADR_RAW:   WB_DATo = 8'(s);
      ADR_DBEN:  WB_DATo = 8'(dben_q);
      ADR_DBCNT: WB_DATo = 8'(dbcnt_q);
      default:   WB_DATo = 8'h00;
    endcase
  end

  assign INT_ARR = int_q;
  assign WB_ACKo = 1'b1;

  logic unused_cfg;
  assign unused_cfg = is_trig_cfg(WB_ADRi);

endmodule

// File: tb/tb_int_src_cond.sv
// tb/tb_int_src_cond.sv - self-checking bench for int_src_cond against a behavioural model
module tb_int_src_cond;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq = 8'h00;
  logic [7:0] int_arr;
  logic [2:0] adr = 3'd0;
  logic [7:0] dat_i = 8'h00;
  logic [7:0] dat_o;
  logic       we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic       ack;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  int_src_cond #(.N(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .IRQ_RAW(irq), .INT_ARR(int_arr),
    .WB_ADRi(adr), .WB_DATi(dat_i), .WB_DATo(dat_o),
    .WB_WEi(we), .WB_CYCi(cyc), .WB_STBi(stb), .WB_ACKo(ack)
  );

  // Behavioural model: s is IRQ_RAW seen two edges late; the filtered value adopts s once s
  // has disagreed with it for DBCNT+1 consecutive edges.
  bit [7:0] m_h0, m_h1, m_fr, m_p, m_pend, m_int, m_trigm, m_pol, m_dben;
  int       m_dbcnt;
  int       m_run [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h0 = 0; m_h1 = 0; m_fr = 0; m_p = 0; m_pend = 0; m_int = 0;
    m_trigm = 0; m_pol = 8'hFF; m_dben = 0; m_dbcnt = 0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
  endtask

  function automatic bit [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return m_trigm;
      3'd1: return m_pol;
      3'd2: return m_pend;
      3'd4: return m_h1;
      3'd5: return m_dben;
      3'd6: return 8'(m_dbcnt);
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge();
    bit [7:0] f, nxt;
    bit       wr, ev, set, clr_cnt;
    wr = cyc && stb && we;
    clr_cnt = wr && (adr == 3'd5 || adr == 3'd6);
    for (int i = 0; i < 8; i++) f[i] = m_dben[i] ? m_fr[i] : m_h1[i];
    for (int i = 0; i < 8; i++) begin
      ev  = m_pol[i] ? (f[i] && !m_p[i]) : (!f[i] && m_p[i]);
      set = m_trigm[i] && (ev || (wr && adr == 3'd3 && dat_i[i]));
      if (wr && adr == 3'd0 && m_trigm[i] && !dat_i[i]) nxt[i] = 0;
      else if (set)                                    nxt[i] = 1;
      else if (wr && adr == 3'd2 && dat_i[i])          nxt[i] = 0;
      else                                             nxt[i] = m_pend[i];
      m_int[i] = m_trigm[i] ? nxt[i] : (f[i] == m_pol[i]);
      if (!m_dben[i]) begin
        m_fr[i] = m_h1[i]; m_run[i] = 0;
      end else if (clr_cnt || m_h1[i] == m_fr[i]) begin
        m_run[i] = 0;
      end else if (m_run[i] == m_dbcnt) begin
        m_fr[i] = m_h1[i]; m_run[i] = 0;
      end else begin
        m_run[i]++;
      end
    end
    m_p = f; m_pend = nxt; m_h1 = m_h0; m_h0 = irq;
    if (wr) begin
      case (adr)
        3'd0: m_trigm = dat_i;
        3'd1: m_pol = dat_i;
        3'd5: m_dben = dat_i;
        3'd6: m_dbcnt = int'(dat_i);
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("int_arr", {24'd0, int_arr}, {24'd0, m_int});
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    cyc = 1; stb = 1; we = 1; adr = a; dat_i = d;
    tick();
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic rd(input logic [2:0] a);
    cyc = 1; stb = 1; we = 0; adr = a;
    #1;
    chk($sformatf("rd_adr%0d", a), {24'd0, dat_o}, {24'd0, m_read(a)});
    cyc = 0; stb = 0;
  endtask

  int lat;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // Reset state
    repeat (4) tick();
    chk("rst_int", {24'd0, int_arr}, 32'h00);
    chk("ack", {31'd0, ack}, 32'd1);
    rd(3'd2); rd(3'd0);
    adr = 3'd1; #1; chk("pol_rst", {24'd0, dat_o}, 32'hFF);

    // Level mode, line 3
    irq = 8'h08;
    tick(); chk("lvl_k", {24'd0, int_arr}, 32'h00);
    tick(); chk("lvl_k1", {24'd0, int_arr}, 32'h00);
    tick(); chk("lvl_k2", {24'd0, int_arr}, 32'h08);
    irq = 8'h00;
    repeat (3) tick(); chk("lvl_rel", {24'd0, int_arr}, 32'h00);
    irq = 8'h08;
    wb_write(3'd1, 8'hF7);
    repeat (3) tick(); chk("lvl_inv_hi", {24'd0, int_arr}, 32'h00);
    irq = 8'h00;
    repeat (3) tick(); chk("lvl_inv_lo", {24'd0, int_arr}, 32'h08);
    wb_write(3'd1, 8'hFF);

    // Edge mode, lines 0 and 5
    wb_write(3'd0, 8'h21);
    irq = 8'h21; tick(); irq = 8'h00;
    repeat (4) tick();
    rd(3'd2); chk("edge_pend", {24'd0, dat_o}, 32'h21);
    wb_write(3'd2, 8'h01);
    rd(3'd2); chk("w1c", {24'd0, dat_o}, 32'h20);
    irq = 8'h01; tick(); irq = 8'h00; tick();
    wb_write(3'd2, 8'h01);
    rd(3'd2); chk("set_wins", {24'd0, dat_o}, 32'h21);

    // Glitch filter on line 0, threshold 4
    wb_write(3'd5, 8'h01); wb_write(3'd6, 8'd4);
    wb_write(3'd0, 8'h01); wb_write(3'd2, 8'hFF);
    irq = 8'h01; repeat (4) tick(); irq = 8'h00;
    repeat (12) tick();
    rd(3'd2); chk("filt_short", {24'd0, dat_o}, 32'h00);
    lat = 0;
    irq = 8'h01;
    for (int t = 1; t <= 20; t++) begin
      if (t == 6) irq = 8'h00;
      tick();
      if (int_arr[0] && lat == 0) lat = t;
    end
    chk("filt_lat", lat, 8);
    wb_write(3'd5, 8'h00); wb_write(3'd2, 8'hFF);
    lat = 0;
    irq = 8'h01;
    for (int t = 1; t <= 20; t++) begin
      if (t == 2) irq = 8'h00;
      tick();
      if (int_arr[0] && lat == 0) lat = t;
    end
    chk("nofilt_lat", lat, 3);

    // Software set
    wb_write(3'd0, 8'h80); wb_write(3'd2, 8'hFF);
    wb_write(3'd3, 8'h82);
    chk("swset_int", {24'd0, int_arr}, 32'h80);
    rd(3'd2); chk("swset_pend", {24'd0, dat_o}, 32'h80);
    rd(3'd3);

    // Polarity change with input held high must not create a pending event
    wb_write(3'd0, 8'h04); wb_write(3'd2, 8'hFF);
    irq = 8'h04; repeat (4) tick();
    wb_write(3'd2, 8'hFF);
    wb_write(3'd1, 8'hFB);
    repeat (3) tick();
    rd(3'd2); chk("pol_glitch", {24'd0, dat_o}, 32'h00);

    // Asynchronous reset with everything pending
    wb_write(3'd0, 8'hFF); wb_write(3'd3, 8'hFF);
    tick(); chk("all_pend", {24'd0, int_arr}, 32'hFF);
    #2 rst = 0;
    #1 chk("async_rst", {24'd0, int_arr}, 32'h00);
    model_reset();
    irq = 8'h00;
    @(posedge clk); #1 rst = 1;
    repeat (3) tick();
    rd(3'd1);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      irq = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        cyc = 1; stb = ($urandom_range(0, 7) != 0); we = 1;
        adr = 3'($urandom_range(0, 7));
        dat_i = (adr == 3'd6) ? 8'($urandom_range(0, 6)) : 8'($urandom);
        tick();
        cyc = 0; stb = 0; we = 0;
      end else begin
        tick();
      end
      if ($urandom_range(0, 3) == 0) rd(3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/int_src_cond.md
Name: int_src_cond

Overview:
Per-line interrupt source conditioner that sits directly upstream of the SoC-LS1u interrupt controller and drives its 8-bit INT_ARR input.
- Synchronises raw peripheral/pin interrupt requests to clk.
- Applies an optional glitch filter.
- Selects level or edge triggering and polarity per line.
- Latches edge events as pending bits; software clears them write-1-to-clear (W1C) over the same 8-bit Wishbone register bus used by the interrupt controller.

Parameters:
- N, 8, number of interrupt lines (register map supports N<=8).
- SYNC_STAGES, 2, synchroniser flops per line (>=2).
- CNT_W, 8, glitch-filter counter width (equals DBCNT register width).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted 0)
- IRQ_RAW  in  N  unsynchronised interrupt requests
- INT_ARR  out  N  conditioned requests to interrupt controller, registered
- WB_ADRi  in  3  register address
- WB_DATi  in  8  write data
- WB_DATo  out  8  read data, combinational mux
- WB_WEi  in  1  write enable
- WB_CYCi  in  1  bus cycle
- WB_STBi  in  1  strobe
- WB_ACKo  out  1  constant 1, zero-wait-state

Behaviour:
Registers. A write occurs when CYC&STB&WE, at the clk edge.
- 0x0 TRIGM (RW, reset 0x00): 1 = edge, 0 = level.
- 0x1 POL (RW, reset 0xFF): edge 1 = rising / 0 = falling; level 1 = high / 0 = low.
- 0x2 PEND (R/W1C, reset 0x00): edge-mode pending bits.
- 0x3 SWSET (W1S, reads 0x00): writing 1 sets PEND[i] for edge-mode lines; no effect on level-mode lines.
- 0x4 RAW (RO): synchronised inputs s[i].
- 0x5 DBEN (RW, reset 0x00): per-line filter enable.
- 0x6 DBCNT (RW, reset 0x00): filter threshold.
- 0x7: reads 0, writes ignored.
- Bits >= N read 0.

Reset: all flops cleared asynchronously when rst=0, to the values above. Synchronisers, filter outputs, counters, edge history and INT_ARR reset to 0. Release is synchronous to clk in the system.

Synchroniser: SYNC_STAGES-flop chain per line; output s[i].

Filter (per line), producing f[i]:
- DBEN[i]=0: f[i]=s[i] combinationally; counter held at 0.
- DBEN[i]=1: counter c[i] increments each cycle s[i]!=f[i], and clears when s[i]==f[i].
- When s[i]!=f[i] and c[i]==DBCNT: f[i]<=s[i] and c[i]<=0.
- A pulse shorter than DBCNT+1 cycles never reaches f. DBCNT=0 gives a 1-cycle register delay.
- Counter saturates at DBCNT; it never wraps.

Edge detect: p[i] = registered f[i].
- Rising event: f & ~p. Falling event: ~f & p. The event used is selected by POL[i].

Pending (edge mode):
- PEND[i] sets on an event or a SWSET write, and clears on a W1C write to PEND.
- Set and clear in the same cycle: set wins, so no event is lost.

Output, registered each cycle:
- INT_ARR[i] = TRIGM[i] ? PEND[i] : (f[i] ~^ POL[i]).

Latency, filter off, edge mode, SYNC_STAGES=2: a pin change captured at edge k gives an event at edge k+2, PEND and INT_ARR high after edge k+2, visible to the controller at edge k+3. Level mode has the same latency. Filter on adds DBCNT+1 cycles.

Config writes:
- Writing TRIGM or POL loads p[i]<=f[i] for all lines in that cycle, so no spurious edge is generated.
- Clearing TRIGM[i] clears PEND[i].
- Writing DBEN or DBCNT clears all counters.

Mid-operation reset: all state is lost and INT_ARR drops to 0 immediately (asynchronously).

Decomposition:
- Package int_src_pkg: register address constants (ADR_TRIGM..ADR_DBCNT) and reset values (POL_RST=8'hFF).
- Sub-module int_line_filter, instantiated N times: synchroniser, glitch counter, f/p flops, rise/fall event output.
- Top level holds the registers, pending logic, output register and bus mux.

Test Plan:
- Reset, then idle with IRQ_RAW=0: INT_ARR=0x00 and PEND=0x00. Read POL=0xFF, TRIGM=0x00.
- Level mode, POL=0xFF: IRQ_RAW[3] 0->1 captured at edge k gives INT_ARR=0x08 after edge k+2. Releasing the input clears it with the same latency. With POL[3]=0 the output inverts.
- Edge mode on lines 0 and 5, rising: 1-cycle pulses on both set PEND=0x21. Writing 0x01 to PEND leaves 0x20. A new rising event on line 0 in the same cycle as a W1C to bit 0 keeps PEND[0]=1.
- Filter: DBEN=0x01, DBCNT=4, edge mode. A 4-cycle high pulse on line 0 leaves PEND=0. A 5-cycle pulse sets PEND[0] 5 cycles later than the unfiltered path.
- SWSET: write 0x82 with TRIGM=0x80. Only PEND[7] sets and INT_ARR=0x80. Reading SWSET returns 0x00.
- Config glitch: hold IRQ_RAW[2]=1 and write POL[2] 1->0 in edge mode. No pending is set. Assert rst=0 while PEND=0xFF: INT_ARR=0 before the next clk edge.
